// File: rtl/audio_pkg.sv
// Shared audio types and constants for the codec ADC and DAC blocks.
package audio_pkg;

    localparam int unsigned AUDIO_DATA_WIDTH = 24;

    // LRCK level for each channel
    localparam logic LEFT_CH  = 1'b0;
    localparam logic RIGHT_CH = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StLeft,
        StRight
    } audio_state_e;

endpackage

// File: rtl/audio_sync_edge.sv
// N-stage synchroniser for one asynchronous input, with registered rise/fall strobes.
// o_q is delayed by one extra stage so that it lines up with the strobes.
module audio_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_q;
    logic              r_rise;
    logic              r_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_q    <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_q    <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_q;
            r_fall <= ~r_sync[STAGES-1] & r_q;
        end
    end

    assign o_q    = r_q;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/audio_adc_i2s_rx.sv
// I2S slave receiver for the codec ADC path: deserialises L/R words into a valid/ready pair stream.
// Define AUDIO_RX_OVF_COUNT_EN to add the saturating dropped-pair counter output ovf_count.
module audio_adc_i2s_rx
    import audio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = AUDIO_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  audio_BCLK,
    input  logic                  audio_ADCLRCK,
    input  logic                  audio_ADCDAT,
    output logic [DATA_WIDTH-1:0] out_left,
    output logic [DATA_WIDTH-1:0] out_right,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    output logic                  frame_error,
`ifdef AUDIO_RX_OVF_COUNT_EN
    output logic [15:0]           ovf_count,
`endif
    input  logic                  clear_flags
);

    localparam int unsigned        CNT_W    = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_SAT  = CNT_W'(DATA_WIDTH + 1);

    logic w_bclk_rise, w_lrck, w_dat;
    logic w_bclk_q_unused, w_bclk_fall_unused;
    logic w_lrck_rise_unused, w_lrck_fall_unused, w_dat_rise_unused, w_dat_fall_unused;

    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk    (clk),
        .reset  (reset),
        .i_d    (audio_BCLK),
        .o_q    (w_bclk_q_unused),
        .o_rise (w_bclk_rise),
        .o_fall (w_bclk_fall_unused)
    );

    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk    (clk),
        .reset  (reset),
        .i_d    (audio_ADCLRCK),
        .o_q    (w_lrck),
        .o_rise (w_lrck_rise_unused),
        .o_fall (w_lrck_fall_unused)
    );

    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dat (
        .clk    (clk),
        .reset  (reset),
        .i_d    (audio_ADCDAT),
        .o_q    (w_dat),
        .o_rise (w_dat_rise_unused),
        .o_fall (w_dat_fall_unused)
    );

    audio_state_e          r_state, w_state_d;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-2:0] r_shift;
    logic [DATA_WIDTH-1:0] r_left_hold;
    logic                  r_left_ok;
    logic                  r_lrck_last;
    logic [DATA_WIDTH-1:0] r_out_left, r_out_right;
    logic                  r_out_valid, r_overflow, r_frame_error;

    logic [DATA_WIDTH-1:0] w_word;
    logic w_lrck_chg, w_shift, w_word_done, w_short, w_pair_done, w_load, w_drop;

    // r_cnt is the rise index since the last LRCK change; index 0 is the I2S delay bit
    assign w_lrck_chg  = w_bclk_rise && (w_lrck != r_lrck_last);
    assign w_shift     = w_bclk_rise && !w_lrck_chg && (r_cnt <= CNT_LAST);
    assign w_word_done = w_shift && (r_cnt == CNT_LAST);
    assign w_word      = {r_shift, w_dat};
    assign w_short     = enable && w_lrck_chg && (r_cnt <= CNT_LAST) &&
                         ((r_state == StLeft) || (r_state == StRight));
    assign w_pair_done = enable && (r_state == StRight) && w_word_done && r_left_ok;
    assign w_load      = w_pair_done && (!r_out_valid || out_ready);
    assign w_drop      = w_pair_done && !w_load;

    always_comb begin
        w_state_d = r_state;
        if (!enable) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle:  w_state_d = StSync;
                StSync:  if (w_lrck_chg && (w_lrck == LEFT_CH)) w_state_d = StLeft;
                StLeft:  if (w_lrck_chg && (w_lrck == RIGHT_CH)) w_state_d = StRight;
                StRight: if (w_lrck_chg && (w_lrck == LEFT_CH)) w_state_d = StLeft;
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_left_hold <= '0;
            r_left_ok   <= 1'b0;
            r_lrck_last <= LEFT_CH;
        end else begin
            r_state <= w_state_d;
            if (w_bclk_rise) r_lrck_last <= w_lrck;
            if (r_state == StIdle) begin
                r_cnt     <= '0;
                r_shift   <= '0;
                r_left_ok <= 1'b0;
            end else if (w_lrck_chg) begin
                r_cnt <= '0;
                // a new frame starts on the LRCK fall; any earlier left word is stale
                if (w_lrck == LEFT_CH) r_left_ok <= 1'b0;
            end else if (w_bclk_rise) begin
                if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
                if (w_shift) r_shift <= w_word[DATA_WIDTH-2:0];
                if (w_word_done && (r_state == StLeft)) begin
                    r_left_hold <= w_word;
                    r_left_ok   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_left    <= '0;
            r_out_right   <= '0;
            r_out_valid   <= 1'b0;
            r_overflow    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_left  <= r_left_hold;
                r_out_right <= w_word;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (clear_flags) begin
                r_overflow    <= 1'b0;
                r_frame_error <= 1'b0;
            end else begin
                if (w_drop) r_overflow <= 1'b1;
                if (w_short) r_frame_error <= 1'b1;
            end
        end
    end

`ifdef AUDIO_RX_OVF_COUNT_EN
    logic [15:0] r_ovf_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf_count <= '0;
        end else if (clear_flags) begin
            r_ovf_count <= '0;
        end else if (w_drop && (r_ovf_count != 16'hFFFF)) begin
            r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign ovf_count = r_ovf_count;
`endif

    assign out_left    = r_out_left;
    assign out_right   = r_out_right;
    assign out_valid   = r_out_valid;
    assign overflow    = r_overflow;
    assign frame_error = r_frame_error;

endmodule

// File: tb/tb_audio_adc_i2s_rx.sv
// Directed bench for audio_adc_i2s_rx: drives I2S frames from the codec side and checks the pair stream.
// With AUDIO_RX_OVF_COUNT_EN defined the dropped-pair counter is checked as well.
module tb_audio_adc_i2s_rx;
    import audio_pkg::*;

    localparam int DW   = 24;
    localparam int SS   = 2;
    localparam int HALF = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          bclk = 1'b0;
    logic          lrck = 1'b1;
    logic          dat = 1'b0;
    logic          out_ready = 1'b0;
    logic          clear_flags = 1'b0;
    logic [DW-1:0] out_left, out_right;
    logic          out_valid, overflow, frame_error;
`ifdef AUDIO_RX_OVF_COUNT_EN
    logic [15:0]   ovf_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int cyc_last = 0;
    int cyc_vrise = 0;
    logic prev_valid = 1'b0;
    logic [2*DW-1:0] xfer_q[$];
    event ev_last;

    audio_adc_i2s_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .audio_BCLK    (bclk),
        .audio_ADCLRCK (lrck),
        .audio_ADCDAT  (dat),
        .out_left      (out_left),
        .out_right     (out_right),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .overflow      (overflow),
        .frame_error   (frame_error),
`ifdef AUDIO_RX_OVF_COUNT_EN
        .ovf_count     (ovf_count),
`endif
        .clear_flags   (clear_flags)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && out_ready) xfer_q.push_back({out_left, out_right});
        if (out_valid && !prev_valid) cyc_vrise = cyc;
        prev_valid = out_valid;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One BCLK period: data/LRCK change on the fall, codec samples on the rise
    task automatic slot(input logic l, input logic d, input logic mark);
        bclk = 1'b0;
        lrck = l;
        dat  = d;
        repeat (HALF) @(posedge clk);
        #2;
        bclk = 1'b1;
        if (mark) begin
            cyc_last = cyc;
            -> ev_last;
        end
        repeat (HALF) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int lbits);
        int nl;
        nl = (lbits < DW) ? lbits + 1 : 32;
        for (int s = 0; s < nl; s++) slot(LEFT_CH, (s >= 1 && s <= DW) ? l[DW-s] : 1'b0, 1'b0);
        for (int s = 0; s < 32; s++)
            slot(RIGHT_CH, (s >= 1 && s <= DW) ? r[DW-s] : 1'b0, (s == DW) ? 1'b1 : 1'b0);
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #2 clear_flags = 1'b1;
        @(posedge clk);
        #2 clear_flags = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_left", out_left, 0);
        check("rst_right", out_right, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ferr", frame_error, 0);
        @(posedge clk);
        #2;
        reset  = 1'b0;
        enable = 1'b1;
        repeat (4) slot(RIGHT_CH, 1'b0, 1'b0);

        // Hold a pair, then reset in the middle of the next frame
        send_frame(24'hDEAD01, 24'hBEEF02, DW);
        @(negedge clk);
        check("held_before_rst", out_valid, 1);
        fork
            send_frame(24'hC0FFEE, 24'h0BADF0, DW);
            begin
                repeat (700) @(posedge clk);
                #3 reset = 1'b1;
                repeat (3) @(posedge clk);
                #3 reset = 1'b0;
                @(negedge clk);
                check("post_rst_left", out_left, 0);
                check("post_rst_right", out_right, 0);
                check("post_rst_valid", out_valid, 0);
            end
        join
        @(negedge clk);
        check("post_rst_no_pair", out_valid, 0);
        check("post_rst_ovf", overflow, 0);

        // Basic capture with latency
        out_ready = 1'b1;
        send_frame(24'h123456, 24'hABCDEF, DW);
        check("basic_count", xfer_q.size(), 1);
        check("basic_pair", xfer_q[0], {24'h123456, 24'hABCDEF});
        check("basic_latency", cyc_vrise - cyc_last, SS + 2);
        check("basic_valid_drop", out_valid, 0);

        // Enable rises mid-left word: that frame must not be emitted
        enable = 1'b0;
        fork
            send_frame(24'h111111, 24'h222222, DW);
            begin
                repeat (100) @(posedge clk);
                #2 enable = 1'b1;
            end
        join
        check("en_partial_none", xfer_q.size(), 1);
        send_frame(24'h333333, 24'h444444, DW);
        check("en_next_count", xfer_q.size(), 2);
        check("en_next_pair", xfer_q[1], {24'h333333, 24'h444444});

        // Back-pressure for three frames
        out_ready = 1'b0;
        send_frame(24'h7FFFFF, 24'h800000, DW);
        check("bp1_valid", out_valid, 1);
        check("bp1_ovf", overflow, 0);
        send_frame(24'h000001, 24'hFFFFFF, DW);
        check("bp2_ovf", overflow, 1);
        check("bp2_hold", {out_left, out_right}, {24'h7FFFFF, 24'h800000});
        send_frame(24'h13579B, 24'h2468AC, DW);
        check("bp3_hold", {out_left, out_right}, {24'h7FFFFF, 24'h800000});
`ifdef AUDIO_RX_OVF_COUNT_EN
        check("bp3_ovf_count", ovf_count, 2);
`endif
        pulse_clear();
        check("bp_clear_ovf", overflow, 0);
        check("bp_clear_valid", out_valid, 1);
`ifdef AUDIO_RX_OVF_COUNT_EN
        check("bp_clear_count", ovf_count, 0);
`endif
        @(posedge clk);
        #2 out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("bp_drain_count", xfer_q.size(), 3);
        check("bp_drain_pair", xfer_q[2], {24'h7FFFFF, 24'h800000});
        check("bp_drain_valid", out_valid, 0);

        // Short left word
        send_frame(24'h555555, 24'h666666, 20);
        check("short_ferr", frame_error, 1);
        check("short_no_pair", xfer_q.size(), 3);
        send_frame(24'h777777, 24'h888888, DW);
        check("short_next_count", xfer_q.size(), 4);
        check("short_next_pair", xfer_q[3], {24'h777777, 24'h888888});
        pulse_clear();
        check("short_clear", frame_error, 0);

        // Accept of the held pair in the same cycle a new pair completes
        out_ready = 1'b0;
        send_frame(24'h0A0A0A, 24'h0B0B0B, DW);
        fork
            send_frame(24'h0C0C0C, 24'h0D0D0D, DW);
            begin
                @(ev_last);
                repeat (SS + 1) @(posedge clk);
                #2 out_ready = 1'b1;
                @(negedge clk);
                check("sim_old_valid", out_valid, 1);
                check("sim_old_left", out_left, 24'h0A0A0A);
                @(negedge clk);
                check("sim_new_valid", out_valid, 1);
                check("sim_new_pair", {out_left, out_right}, {24'h0C0C0C, 24'h0D0D0D});
                @(negedge clk);
                check("sim_valid_drop", out_valid, 0);
            end
        join
        check("sim_ovf", overflow, 0);
        check("sim_count", xfer_q.size(), 6);
        check("sim_pair_old", xfer_q[4], {24'h0A0A0A, 24'h0B0B0B});
        check("sim_pair_new", xfer_q[5], {24'h0C0C0C, 24'h0D0D0D});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_adc_i2s_rx.md
Name: audio_adc_i2s_rx

Overview:
- I2S receiver (slave) for the codec ADC path: the capture-side counterpart of the existing audio DAC transmitter, which is fed by audio_BCLK/audio_DACLRCK/audio_DACDAT.
- Codec is bit-clock and LR-clock master; this block oversamples audio_BCLK, audio_ADCLRCK and audio_ADCDAT in the system clock domain.
- Deserialises MSB-first two's-complement words and emits left/right sample pairs on a valid/ready stream toward HPS-visible capture logic.

Parameters:
- DATA_WIDTH, 24, bits per channel word captured (legal 16..32).
- SYNC_STAGES, 2, flip-flop stages per external input synchroniser (≥2).

Ports:
- clk  in  1  system clock (50 MHz); must be ≥4× BCLK.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable.
- audio_BCLK  in  1  codec bit clock, asynchronous to clk.
- audio_ADCLRCK  in  1  codec ADC LR clock: 0 = left, 1 = right.
- audio_ADCDAT  in  1  codec ADC serial data.
- out_left  out  DATA_WIDTH  left sample of the presented pair.
- out_right  out  DATA_WIDTH  right sample of the presented pair.
- out_valid  out  1  pair available.
- out_ready  in  1  consumer accepts the pair.
- overflow  out  1  sticky: a completed pair was dropped.
- frame_error  out  1  sticky: a channel word was shorter than DATA_WIDTH bits.
- clear_flags  in  1  synchronous clear of overflow and frame_error.

Behaviour:
- Reset values: out_left=0, out_right=0, out_valid=0, overflow=0, frame_error=0. FSM=IDLE, bit counter=0, shift register=0.
- Synchronisers: SYNC_STAGES FFs on each external input.
- BCLK rise is detected on a 0→1 transition of synced BCLK (one-cycle strobe). All LRCK/data sampling happens only on this strobe.
- Per strobe, a counter tracks bit position, which is the rise index since the last LRCK change:
  - Index 0 is the rise on which the LRCK change is first seen. That bit is ignored (I2S one-bit delay).
  - Indices 1..DATA_WIDTH shift data in MSB first.
  - Indices >DATA_WIDTH are ignored; the counter saturates.
- FSM:
  - IDLE: entered when enable=0 from any state. The partial word is discarded; the counter is held at 0. Leaves to SYNC when enable=1.
  - SYNC: waits for a strobe on which LRCK falls 1→0, then goes to LEFT. Partial frames are never emitted.
  - LEFT: when DATA_WIDTH bits are shifted, the word is latched to an internal left hold register. LRCK rising goes to RIGHT.
  - RIGHT: when DATA_WIDTH bits are shifted, the pair is complete. LRCK falling goes to LEFT.
- Short word: if LRCK toggles before DATA_WIDTH bits are captured in the current channel:
  - frame_error is set and the current pair is abandoned (no output).
  - The FSM still follows LRCK.
- Pair completion: the strobe of right bit DATA_WIDTH is cycle N.
  - If out_valid=0, or out_ready=1 in cycle N, out_left/out_right load and out_valid=1 in cycle N+1.
  - Otherwise the new pair is dropped, the held outputs are kept, and overflow=1.
- Handshake: a transfer occurs on any cycle with out_valid&&out_ready. out_valid drops the next cycle unless a new pair loads in the same cycle; in that case it stays 1 with the new data.
  - out_left/out_right are stable while out_valid=1 and not accepted.
- clear_flags has priority over a same-cycle set: both flags are 0 next cycle. The event in that cycle is lost from the flags.
- enable deassertion while out_valid=1: the pending pair remains presented until accepted.
- Latency: last right bit on the ADCDAT pin to out_valid = SYNC_STAGES+2 clk cycles.

Optional Feature:
- AUDIO_RX_OVF_COUNT_EN:
  - Defined: adds output ovf_count [15:0], reset 0. It increments on every dropped pair and saturates at 0xFFFF. It is cleared by clear_flags, and clear has priority over a same-cycle increment.
  - Undefined: the port and counter are absent; overflow flag behaviour is unchanged.

Decomposition:
- Shared package audio_pkg holds:
  - the FSM state typedef (IDLE, SYNC, LEFT, RIGHT);
  - the default DATA_WIDTH constant 24;
  - the LRCK channel encoding constants (LEFT_CH=0, RIGHT_CH=1).
  These are reused by the DAC-side block.
- One natural sub-module: audio_sync_edge, an N-stage synchroniser with rise/fall strobe outputs. It is instantiated for BCLK; LRCK and ADCDAT use the synchroniser portion only.

Test Plan:
- Reset mid-stream → after reset release, all outputs are 0 and no out_valid until a full left+right frame follows an LRCK fall.
- enable=1, BCLK=3.072 MHz, DATA_WIDTH=24, left=0x123456, right=0xABCDEF, out_ready=1 → one pulse with out_left=0x123456, out_right=0xABCDEF, exactly SYNC_STAGES+2 cycles after the last right bit.
- Enable asserted while LRCK=0 mid-left word → the first emitted pair is from the next complete frame; the partial frame is never emitted.
- out_ready=0 for 3 frames → the first pair is held stable and overflow=1 after frame 2. With AUDIO_RX_OVF_COUNT_EN, ovf_count=2; clear_flags → both 0.
- LRCK toggles after 20 of 24 left bits → frame_error=1 and no pair for that frame; the next well-formed frame is emitted normally.
- Simultaneous accept (out_ready=1) and new pair completion in the same cycle → out_valid stays 1, data updates to the new pair, overflow stays 0.
